booth_seq_arb: RTL and testbench
================================

BOOTH_SEQ_ARB -- requirements
Module: booth_seq_arb

Interface
REQ-001 Parameter: WIDTH, 16, operand width driven to the Booth datapath.
REQ-002 Parameter: CNT_INIT, 16, iteration count loaded into the datapath counter; equals WIDTH.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req0 / req1  input  1 each  multiply request per requester; level, held until that requester's done.
REQ-006 Port: a0, b0 / a1, b1  input  WIDTH each  multiplier (a) and multiplicand (b) per requester.
REQ-007 Port: done0 / done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-008 Port: busy  output  1  high from INIT through DONE inclusive.
REQ-009 Port: gnt_id  output  1  registered index of the requester being served.
REQ-010 Port: mul_q, mul_m  output  WIDTH each  to datapath in1/in2; mul_q=a[gnt], mul_m=b[gnt].
REQ-011 Port: ldA, ldQ, ldM, clrA, clrQ, clrDff, sftA, sftQ, addsub, decr, ldCount  output  1 each  datapath controls.
REQ-012 Port: Q0, Qm1, isCountZero  input  1 each  datapath status.

Function
REQ-013 States SHALL be IDLE, INIT, EVAL, SHIFT and DONE; the state register is one-hot or binary, implementer's choice.
REQ-014 Every datapath control SHALL default to 0 in every state unless this section asserts it.
REQ-015 IDLE SHALL arbitrate when either request is high:
- single request: that requester wins
- both high: the requester named by the round-robin pointer wins
- winner stored in gnt_id; next state is INIT
REQ-016 The round-robin pointer SHALL move to the non-served requester on entry to DONE.
REQ-017 Requests SHALL be sampled only in IDLE; request changes while busy are ignored.
REQ-018 INIT SHALL assert ldQ, ldM, clrA, clrDff and ldCount (counter loaded with CNT_INIT), with mul_q/mul_m selected by gnt_id; next state is EVAL.
REQ-019 EVAL SHALL branch as follows:
- isCountZero=1: go to DONE with no datapath control asserted
- {Q0,Qm1}=01: assert ldA with addsub=1 (A+M)
- {Q0,Qm1}=10: assert ldA with addsub=0 (A-M)
- {Q0,Qm1}=00 or 11: no ldA
- in all non-zero cases, next state is SHIFT
REQ-020 Q0/Qm1 SHALL be consumed only in EVAL, i.e. the cycle immediately after INIT or SHIFT, because Qm1 reloads every clock.
REQ-021 SHIFT SHALL assert sftA, sftQ and decr together; next state is EVAL.
REQ-022 DONE SHALL pulse done[gnt_id] for exactly one cycle, then return to IDLE; the product {A,Q} stays valid in the datapath until the next INIT.
REQ-023 Latency: request accepted in IDLE at cycle 0 -> INIT at cycle 1 -> EVAL at even cycles 2..34, SHIFT at odd cycles 3..33 -> done at cycle 35. This SHALL be fixed and independent of operand values.
REQ-024 A requester still asserting req in the IDLE cycle after its done SHALL be treated as a new request, subject to round-robin.
REQ-025 The block SHALL perform no operand width checks; signed two's-complement semantics are implied by the datapath.

Reset
REQ-026 While rst=1 at a clock edge:
- state -> IDLE
- gnt_id=0, round-robin pointer -> requester 0
- busy=0, done0=done1=0, all datapath controls 0
REQ-027 Reset asserted mid-operation SHALL abort the multiply with no done pulse; datapath contents are don't-care afterwards.
REQ-028 mul_q/mul_m SHALL follow gnt_id combinationally, so they equal a0/b0 after reset.

Verification
REQ-029 Only req0, a0=3, b0=5 -> done0 at cycle 35, {A,Q}=32'h0000000F, busy high cycles 1..35.
REQ-030 Only req1, a1=-3 (16'hFFFD), b1=7 -> done1 at cycle 35, {A,Q}=32'hFFFFFFEB; EVAL shows 10 then 01 transitions with matching addsub.
REQ-031 req0 and req1 high in the same cycle after reset -> req0 served first (done0 at cycle 35), req1 served next (INIT at cycle 37, done1 at cycle 71).
REQ-032 rst pulsed at cycle 10 of an operation -> IDLE next cycle, all outputs 0, no done; a following request completes normally.
REQ-033 a0=16'h8000, b0=16'h8000 -> product 32'h40000000; a0=0 -> product 0; both take exactly 35 cycles.
REQ-034 Control check at every cycle: exactly one of {ldA, sftA/sftQ/decr group} or neither is active; ldA never coincides with sftA.

Source files
------------

// File: rtl/booth_seq_arb.sv
// Two-requester round-robin controller for a sequential radix-2 Booth multiplier datapath.
// Drives operand selection and datapath strobes; product {A,Q} lives in the external datapath.
module booth_seq_arb #(
    parameter int WIDTH    = 16,
    parameter int CNT_INIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             gnt_id,
    output logic [WIDTH-1:0] mul_q,
    output logic [WIDTH-1:0] mul_m,
    output logic             ldA,
    output logic             ldQ,
    output logic             ldM,
    output logic             clrA,
    output logic             clrQ,
    output logic             clrDff,
    output logic             sftA,
    output logic             sftQ,
    output logic             addsub,
    output logic             decr,
    output logic             ldCount,
    input  logic             Q0,
    input  logic             Qm1,
    input  logic             isCountZero
);

    // The datapath counter is loaded with CNT_INIT; the fixed latency assumes one iteration per bit.
    if (CNT_INIT != WIDTH) begin : g_cnt_check
        $error("booth_seq_arb: CNT_INIT must equal WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   rr_q, rr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        done0   = 1'b0;
        done1   = 1'b0;
        ldA     = 1'b0;
        ldQ     = 1'b0;
        ldM     = 1'b0;
        clrA    = 1'b0;
        clrQ    = 1'b0;
        clrDff  = 1'b0;
        sftA    = 1'b0;
        sftQ    = 1'b0;
        addsub  = 1'b0;
        decr    = 1'b0;
        ldCount = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contention resolved by the pointer; otherwise the lone requester wins.
                    gnt_d   = (req0 && req1) ? rr_q : req1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                ldQ     = 1'b1;
                ldM     = 1'b1;
                clrA    = 1'b1;
                clrDff  = 1'b1;
                ldCount = 1'b1;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (isCountZero) begin
                    rr_d    = ~gnt_q;
                    state_d = S_DONE;
                end else begin
                    // Qm1 reloads every clock, so the bit pair is only meaningful here.
                    unique case ({Q0, Qm1})
                        2'b01: begin
                            ldA    = 1'b1;
                            addsub = 1'b1;
                        end
                        2'b10: ldA = 1'b1;
                        default: ;
                    endcase
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sftA    = 1'b1;
                sftQ    = 1'b1;
                decr    = 1'b1;
                state_d = S_EVAL;
            end
            S_DONE: begin
                done0   = ~gnt_q;
                done1   = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign gnt_id = gnt_q;
    assign mul_q  = gnt_q ? a1 : a0;
    assign mul_m  = gnt_q ? b1 : b0;

endmodule

// File: tb/tb_booth_seq_arb.sv
// Bench for booth_seq_arb: Booth datapath model, vector table, random ops, corner sequences.
module tb_booth_seq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        done0, done1, busy, gnt_id;
    logic [15:0] mul_q, mul_m;
    logic        ldA, ldQ, ldM, clrA, clrQ, clrDff, sftA, sftQ, addsub, decr, ldCount;
    logic        Q0, Qm1, isCountZero;

    int nchk = 0;
    int nerr = 0;
    bit mon_en = 1'b0;
    bit obs_q[$];

    booth_seq_arb #(.WIDTH(16), .CNT_INIT(16)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .busy(busy), .gnt_id(gnt_id),
        .mul_q(mul_q), .mul_m(mul_m),
        .ldA(ldA), .ldQ(ldQ), .ldM(ldM), .clrA(clrA), .clrQ(clrQ), .clrDff(clrDff),
        .sftA(sftA), .sftQ(sftQ), .addsub(addsub), .decr(decr), .ldCount(ldCount),
        .Q0(Q0), .Qm1(Qm1), .isCountZero(isCountZero)
    );

    always #5 clk = ~clk;

    // Booth datapath: accumulator carries one guard bit so M = -2^15 subtracts correctly.
    logic [16:0] dpA = '0;
    logic [15:0] dpQ = '0;
    logic [15:0] dpM = '0;
    logic        dpQm1 = 1'b0;
    int          dpCnt = 0;

    always @(posedge clk) begin
        if (clrA)      dpA <= '0;
        else if (ldA)  dpA <= addsub ? dpA + {dpM[15], dpM} : dpA - {dpM[15], dpM};
        else if (sftA) dpA <= {dpA[16], dpA[16:1]};
        if (ldQ)       dpQ <= mul_q;
        else if (sftQ) dpQ <= {dpA[0], dpQ[15:1]};
        if (ldM)       dpM <= mul_m;
        dpQm1 <= clrDff ? 1'b0 : dpQ[0];
        if (ldCount)   dpCnt <= 16;
        else if (decr) dpCnt <= dpCnt - 1;
    end

    assign Q0          = dpQ[0];
    assign Qm1         = dpQm1;
    assign isCountZero = (dpCnt == 0);

    function automatic logic [31:0] product();
        return {dpA[15:0], dpQ};
    endfunction

    function automatic logic [10:0] ctrl();
        return {ldA, ldQ, ldM, clrA, clrQ, clrDff, sftA, sftQ, addsub, decr, ldCount};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Booth recoding of the multiplier: 10 -> subtract (addsub=0), 01 -> add (addsub=1).
    function automatic logic [31:0] exp_recode(input logic [15:0] a);
        logic [31:0] v = 32'd1;
        logic prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (a[i] && !prev)      v = {v[30:0], 1'b0};
            else if (!a[i] && prev) v = {v[30:0], 1'b1};
            prev = a[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] obs_recode();
        logic [31:0] v = 32'd1;
        foreach (obs_q[i]) v = {v[30:0], obs_q[i]};
        return v;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (ldA) obs_q.push_back(addsub);
            chk("ctrl_exclusive",
                32'((ldA && (sftA || sftQ || decr)) || (sftA != sftQ) || (sftA != decr) ||
                    (!busy && (ctrl() != '0 || done0 || done1)) || (done0 && done1)), 32'd0);
        end
    end

    task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string nm);
        int done_cyc = -1;
        int busy_cnt = 0;
        bit gnt_bad = 1'b0;
        bit wrong_done = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_start"}, 32'(busy), 32'd0);
        if (sel) begin a1 = a; b1 = b; a0 = 16'($urandom); b0 = 16'($urandom); req1 = 1'b1; end
        else     begin a0 = a; b0 = b; a1 = 16'($urandom); b1 = 16'($urandom); req0 = 1'b1; end
        obs_q.delete();
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && gnt_id != sel) gnt_bad = 1'b1;
            if (c == 1) chk({nm, "_operands"}, {mul_q, mul_m}, {a, b});
            if (sel ? done0 : done1) wrong_done = 1'b1;
            if (sel ? done1 : done0) begin
                done_cyc = c;
                chk({nm, "_product"}, product(), exp);
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk({nm, "_done_cycle"}, 32'(done_cyc), 32'd35);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd35);
        chk({nm, "_gnt_wrong_done"}, {30'd0, gnt_bad, wrong_done}, 32'd0);
        chk({nm, "_addsub_seq"}, obs_recode(), exp_recode(a));
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic both_race(input bit exp_first, input string nm);
        int done_cyc = -1;
        bit who = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                done_cyc = c;
                who = done1;
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk({nm, "_winner"}, 32'(who), 32'(exp_first));
        chk({nm, "_done_cycle"}, 32'(done_cyc), 32'd35);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        string       nm;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0c, d1c, init1c, ndone;
        logic [31:0] p0, p1;

        vecs[0] = '{1'b0, 16'd3,     16'd5,     32'h0000000F, "req0_3x5"};
        vecs[1] = '{1'b1, 16'hFFFD,  16'd7,     32'hFFFFFFEB, "req1_m3x7"};
        vecs[2] = '{1'b0, 16'h8000,  16'h8000,  32'h40000000, "minxmin"};
        vecs[3] = '{1'b0, 16'h0000,  16'h1234,  32'h00000000, "zero_a"};
        vecs[4] = '{1'b1, 16'h7FFF,  16'h7FFF,  32'h3FFF0001, "maxxmax"};
        vecs[5] = '{1'b0, 16'hFFFF,  16'hFFFF,  32'h00000001, "m1xm1"};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'h1234; b0 = 16'h5678; a1 = 16'hAAAA; b1 = 16'h5555;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", {30'd0, done0, done1}, 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        chk("rst_ctrl", 32'(ctrl()), 32'd0);
        chk("rst_mul", {mul_q, mul_m}, 32'h12345678);
        rst = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].nm);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra = 16'($urandom);
            logic [15:0] rb = 16'($urandom);
            run_op(1'($urandom), ra, rb, ref_mul(ra, rb), "rand");
        end

        // Reset mid-operation: abort with no done, then a normal multiply.
        @(negedge clk);
        a1 = 16'hFFFD; b1 = 16'd7; a0 = 16'h0102; b0 = 16'h0304; req1 = 1'b1;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req1 = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt", 32'(gnt_id), 32'd0);
        chk("abort_ctrl", {21'd0, ctrl()}, {21'd0, done0, done1, 9'd0});
        chk("abort_mul", {mul_q, mul_m}, 32'h01020304);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0 || done1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(1'b1, 16'd5, 16'hFFFE, 32'hFFFFFFF6, "post_abort");

        // Simultaneous requests straight after reset.
        pulse_reset();
        @(negedge clk);
        a0 = 16'd3; b0 = 16'd5; a1 = 16'hFFFD; b1 = 16'd7;
        req0 = 1'b1; req1 = 1'b1;
        d0c = -1; d1c = -1; init1c = -1; p0 = '0; p1 = '0;
        for (int c = 1; c <= 80 && d1c < 0; c++) begin
            @(negedge clk);
            if (done0 && d0c < 0) begin d0c = c; p0 = product(); req0 = 1'b0; end
            if (d0c > 0 && c > d0c && busy && init1c < 0) init1c = c;
            if (done1 && d1c < 0) begin d1c = c; p1 = product(); req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("both_done0_cycle", 32'(d0c), 32'd35);
        chk("both_init1_cycle", 32'(init1c), 32'd37);
        chk("both_done1_cycle", 32'(d1c), 32'd71);
        chk("both_prod0", p0, 32'h0000000F);
        chk("both_prod1", p1, 32'hFFFFFFEB);
        @(negedge clk);

        both_race(1'b0, "rr_after_1");
        both_race(1'b1, "rr_after_0");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
